// File: rtl/gate_monitor_pkg.sv
// Shared types and default parameters for the gate pulse monitor.
package gate_monitor_pkg;

  // INIT: no synchronized edge seen since reset; HIGH/LOW: measuring a segment.
  typedef enum logic [1:0] {
    INIT = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int unsigned CNT_W_DEFAULT       = 16;
  localparam int unsigned MIN_WIDTH_DEFAULT   = 4;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/gate_pulse_monitor_sync_chain.sv
// Multi-flop synchronizer for the asynchronous gate output.
module sync_chain
  import gate_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift din through the chain; every stage returns to RESET_LEVEL on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gate_pulse_monitor.sv
// Observer for a gate-level cell output: synchronizes it, detects edges,
// measures completed segment widths and counts toggles and glitches.
module gate_pulse_monitor
  import gate_monitor_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned MIN_WIDTH   = MIN_WIDTH_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             clear,
  output logic             level,
  output logic             edge_rise,
  output logic             edge_fall,
  output logic             width_valid,
  output logic [CNT_W-1:0] last_width,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] GLITCH_LIMIT = CNT_W'(MIN_WIDTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic sync_level;
  logic level_d_q;
  logic edge_det;
  logic rise_det;
  logic measuring;

  state_t state_q, state_d;

  logic [CNT_W-1:0] width_q,      width_d;
  logic [CNT_W-1:0] last_width_q, last_width_d;
  logic [CNT_W-1:0] toggle_q,     toggle_d;
  logic [CNT_W-1:0] glitch_q,     glitch_d;
  logic             edge_rise_q,  edge_rise_d;
  logic             edge_fall_q,  edge_fall_d;
  logic             width_valid_q, width_valid_d;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_LEVEL(RESET_LEVEL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din),
    .q  (sync_level)
  );

  assign edge_det  = sync_level ^ level_d_q;
  assign rise_det  = sync_level & ~level_d_q;
  assign measuring = (state_q != INIT);

  // Previous synchronized level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_d_q <= RESET_LEVEL;
    end else begin
      level_d_q <= sync_level;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: follow the synchronized level once the first edge is seen.
  always_comb begin
    state_d = state_q;
    if (edge_det) begin
      case (state_q)
        INIT:    state_d = rise_det ? HIGH : LOW;
        HIGH:    if (!rise_det) state_d = LOW;
        LOW:     if (rise_det)  state_d = HIGH;
        default: state_d = INIT;
      endcase
    end
  end

  // Width measurement, strobes and saturating counters; clear wins over any
  // increment and suppresses the width report, but strobes still fire.
  always_comb begin
    width_d       = sat_inc(width_q);
    last_width_d  = last_width_q;
    toggle_d      = toggle_q;
    glitch_d      = glitch_q;
    edge_rise_d   = edge_det & rise_det;
    edge_fall_d   = edge_det & ~rise_det;
    width_valid_d = 1'b0;

    if (edge_det) begin
      width_d = CNT_ONE;
    end

    if (clear) begin
      last_width_d = '0;
      toggle_d     = '0;
      glitch_d     = '0;
    end else if (edge_det) begin
      toggle_d = sat_inc(toggle_q);
      if (measuring) begin
        width_valid_d = 1'b1;
        last_width_d  = width_q;
        if (width_q < GLITCH_LIMIT) begin
          glitch_d = sat_inc(glitch_q);
        end
      end
    end
  end

  // Datapath and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_q       <= '0;
      last_width_q  <= '0;
      toggle_q      <= '0;
      glitch_q      <= '0;
      edge_rise_q   <= 1'b0;
      edge_fall_q   <= 1'b0;
      width_valid_q <= 1'b0;
    end else begin
      width_q       <= width_d;
      last_width_q  <= last_width_d;
      toggle_q      <= toggle_d;
      glitch_q      <= glitch_d;
      edge_rise_q   <= edge_rise_d;
      edge_fall_q   <= edge_fall_d;
      width_valid_q <= width_valid_d;
    end
  end

  assign level       = sync_level;
  assign edge_rise   = edge_rise_q;
  assign edge_fall   = edge_fall_q;
  assign width_valid = width_valid_q;
  assign last_width  = last_width_q;
  assign toggle_cnt  = toggle_q;
  assign glitch_cnt  = glitch_q;

endmodule

// File: doc/gate_pulse_monitor.md
# gate_pulse_monitor

Clocked observer placed directly downstream of a gate-level cell under study, such as the NAND cell output. It samples the gate's asynchronous output, synchronizes it, and detects rising and falling edges. It measures the width of every completed pulse in clock cycles and counts toggles and glitches (pulses narrower than a threshold). The counters give gate-level benches a synthesizable, cycle-accurate summary of output activity that can be compared between the no-SDF and SDF-annotated runs.

## Interface
- CNT_W, 16: width of the toggle counter, glitch counter and width counter.
- MIN_WIDTH, 4: a completed pulse with width < MIN_WIDTH cycles is a glitch. Legal range is 1..2^CNT_W-1.
- SYNC_STAGES, 2: number of synchronizer flops. Minimum is 2.
- RESET_LEVEL, 1'b0: value loaded into every synchronizer flop on reset.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- din  in  1  asynchronous gate output under observation.
- clear  in  1  synchronous counter clear; does not touch the synchronizer or the FSM.
- level  out  1  synchronized level of din (last synchronizer stage).
- edge_rise  out  1  one-cycle strobe on a synchronized 0->1 transition.
- edge_fall  out  1  one-cycle strobe on a synchronized 1->0 transition.
- width_valid  out  1  one-cycle strobe; last_width was updated this cycle.
- last_width  out  CNT_W  width in cycles of the most recently completed segment.
- toggle_cnt  out  CNT_W  number of edges since reset or clear; saturating.
- glitch_cnt  out  CNT_W  number of glitches since reset or clear; saturating.

## Operation
- **Synchronizer**
  - A chain of SYNC_STAGES flops samples din.
  - The last stage drives level.
  - A level_d register holds the previous level for edge detection.
- **FSM states**
  - INIT: after reset; no edge seen yet.
  - HIGH: level is 1 and the segment is measured.
  - LOW: level is 0 and the segment is measured.
- **FSM transitions**
  - From INIT, an edge moves to HIGH on a rise or LOW on a fall. The segment from reset to that first edge is never reported.
  - From HIGH, a fall moves to LOW. From LOW, a rise moves to HIGH.
- **Width counter**
  - Loads 1 on the cycle an edge is detected.
  - Otherwise increments, saturating at 2^CNT_W-1.
- **On an edge while in HIGH or LOW**
  - last_width <= the current width counter value.
  - width_valid is pulsed.
  - glitch_cnt increments if that width < MIN_WIDTH.
- **Toggle counting:** toggle_cnt increments on every edge, including the first edge out of INIT.
- **Saturation:** all counters hold at their maximum value and never wrap.
- **clear**
  - Zeroes toggle_cnt, glitch_cnt and last_width.
  - If clear coincides with an edge, the counters clear to zero and do not increment. The edge strobes and FSM transition still occur. width_valid is suppressed.
- **Known limitation:** a din pulse narrower than one clock period may be missed entirely. The bench must not flag this as a defect.

## Timing
- **Reset values**
  - Synchronizer and level_d hold RESET_LEVEL.
  - level equals RESET_LEVEL.
  - All strobes are 0 and all counters are 0.
  - FSM is in INIT.
- **Reset mid-pulse:** the in-progress measurement is discarded and no width_valid is issued.
- **Latency**
  - din changes and is stable before rising edge N.
  - level changes after edge N+SYNC_STAGES-1.
  - edge_rise/edge_fall, width_valid, and the counter updates are visible after edge N+SYNC_STAGES, for exactly one cycle.
- **Width definition:** the width equals the number of rising clk edges at which level held the segment's value. A din pulse stable across K sampling edges reports last_width = K.
- **Back-to-back edges:** edges on consecutive cycles are each reported, with width = 1.

## Structure
- **Package gate_monitor_pkg:**
  - state enum state_t {INIT, HIGH, LOW}
  - default constants for CNT_W, MIN_WIDTH and SYNC_STAGES
- **Sub-module sync_chain:** parameterized SYNC_STAGES, RESET_LEVEL; ports clk, rst, d, q.
- The top level holds the edge detection, FSM, width counter and saturating counters.

## Test plan
- **Reset:** assert rst for 3 cycles with din=0 -> all outputs 0, level=0, no strobes.
- **NAND stimulus:** a=b=1 (out=0), then a=0 at 100 ns, b=0 at 101 ns, clk period 10 ns -> exactly one edge_rise, toggle_cnt=1, no width_valid (first segment), glitch_cnt=0.
- **Pulse width:** din high for 10 cycles then low -> edge_fall, last_width=10, width_valid for 1 cycle, glitch_cnt=0, toggle_cnt=2.
- **Glitch:** with MIN_WIDTH=4, a 2-cycle low pulse -> last_width=2, glitch_cnt=1.
- **Sub-cycle pulse:** a 3 ns pulse between edges -> no strobe, counters unchanged.
- **Saturation and clear:** CNT_W=4, 20 toggles -> toggle_cnt=15; clear together with an edge -> toggle_cnt=0, edge strobe still asserted; reset mid-pulse -> no width_valid, FSM in INIT.
